// File: rtl/wbn_to_apb_pkg.sv
// Shared types for the Wishbone-to-APB bridge.
// The RESP state is only reachable when WBN2APB_RSP_REG_EN is defined.
package wbn2apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/wbn_to_apb.sv
// Wishbone B3 classic slave to APB master bridge: one Wishbone cycle becomes one SETUP+ACCESS transfer.
// Optional macro WBN2APB_RSP_REG_EN registers ack/err/dat_r, adding a RESP cycle.
module wbn_to_apb
  import wbn2apb_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned SW = DW / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wbn_cyc,
  input  logic          wbn_we,
  input  logic          wbn_stb,
  input  logic [AW-1:0] wbn_adr,
  input  logic [SW-1:0] wbn_sel,
  input  logic [DW-1:0] wbn_dat_w,
  output logic [DW-1:0] wbn_dat_r,
  output logic          wbn_ack,
  output logic          wbn_err,
  output logic          wbn_rty,
  output logic          apb_penable,
  output logic          apb_pwrite,
  output logic [SW-1:0] apb_pstrb,
  output logic [AW-1:0] apb_paddr,
  output logic          apb_psel,
  output logic [DW-1:0] apb_pwdata,
  input  logic [DW-1:0] apb_prdata,
  input  logic          apb_pready,
  input  logic          apb_pslverr
);

  logic   req_c;
  logic   done_c;
  logic   penable_q;
  state_e state_c;

  // Request fields pass straight through; Wishbone holds them until termination.
  assign req_c       = wbn_cyc & wbn_stb;
  assign apb_paddr   = wbn_adr;
  assign apb_pwrite  = wbn_we;
  assign apb_pwdata  = wbn_dat_w;
  assign apb_pstrb   = wbn_we ? wbn_sel : SW'(0);
  assign apb_penable = penable_q;
  assign done_c      = apb_psel & penable_q & apb_pready;
  assign wbn_rty     = 1'b0;

`ifdef WBN2APB_RSP_REG_EN
  logic          resp_q;
  logic          ack_q;
  logic          err_q;
  logic [DW-1:0] dat_r_q;

  // psel is held off during RESP so the master sees the ack before a new SETUP.
  assign apb_psel  = req_c & ~rst & ~resp_q;
  assign wbn_ack   = ack_q & ~rst;
  assign wbn_err   = err_q & ~rst;
  assign wbn_dat_r = dat_r_q;
`else
  assign apb_psel  = req_c & ~rst;
  assign wbn_ack   = done_c & ~apb_pslverr;
  assign wbn_err   = done_c & apb_pslverr;
  assign wbn_dat_r = apb_prdata;
`endif

  // Current phase decoded from the request and the penable register.
  always_comb begin
    state_c = IDLE;
    if (penable_q) begin
      state_c = ACCESS;
    end else if (apb_psel) begin
      state_c = SETUP;
    end
`ifdef WBN2APB_RSP_REG_EN
    if (resp_q) begin
      state_c = RESP;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      penable_q <= 1'b0;
`ifdef WBN2APB_RSP_REG_EN
      resp_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_r_q   <= '0;
`endif
    end else begin
`ifdef WBN2APB_RSP_REG_EN
      resp_q <= 1'b0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
`endif
      unique case (state_c)
        IDLE:   penable_q <= 1'b0;
        SETUP:  penable_q <= 1'b1;
        ACCESS: begin
          // A dropped request abandons the transfer without termination.
          if (!req_c || apb_pready) begin
            penable_q <= 1'b0;
          end
`ifdef WBN2APB_RSP_REG_EN
          if (done_c) begin
            resp_q  <= 1'b1;
            ack_q   <= ~apb_pslverr;
            err_q   <= apb_pslverr;
            dat_r_q <= apb_prdata;
          end
`endif
        end
        RESP:   penable_q <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_wbn_to_apb.sv
// Self-checking bench for wbn_to_apb; honours WBN2APB_RSP_REG_EN when defined.
module tb_wbn_to_apb;

`ifdef WBN2APB_RSP_REG_EN
  localparam int RSP = 1;
`else
  localparam int RSP = 0;
`endif
  localparam int MAXC = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wbn_cyc = 1'b0, wbn_we = 1'b0, wbn_stb = 1'b0;
  logic [31:0] wbn_adr = '0, wbn_dat_w = '0, wbn_dat_r;
  logic [3:0]  wbn_sel = '0, apb_pstrb;
  logic        wbn_ack, wbn_err, wbn_rty;
  logic        apb_penable, apb_pwrite, apb_psel;
  logic [31:0] apb_paddr, apb_pwdata;
  logic [31:0] apb_prdata = '0;
  logic        apb_pready = 1'b0, apb_pslverr = 1'b0;

  int asserts = 0;
  int fails = 0;

  // Observations of the most recent transfer, indexed by cycle (1 = first cycle with req).
  int          obs_cyc;
  logic        obs_ack, obs_err;
  logic [31:0] obs_dat;
  logic        tr_psel [MAXC+1];
  logic        tr_pen  [MAXC+1];
  logic        tr_pwr  [MAXC+1];
  logic [31:0] tr_paddr[MAXC+1];
  logic [31:0] tr_pwd  [MAXC+1];
  logic [3:0]  tr_pstrb[MAXC+1];

  wbn_to_apb dut (
    .clk(clk), .rst(rst),
    .wbn_cyc(wbn_cyc), .wbn_we(wbn_we), .wbn_stb(wbn_stb), .wbn_adr(wbn_adr),
    .wbn_sel(wbn_sel), .wbn_dat_w(wbn_dat_w), .wbn_dat_r(wbn_dat_r),
    .wbn_ack(wbn_ack), .wbn_err(wbn_err), .wbn_rty(wbn_rty),
    .apb_penable(apb_penable), .apb_pwrite(apb_pwrite), .apb_pstrb(apb_pstrb),
    .apb_paddr(apb_paddr), .apb_psel(apb_psel), .apb_pwdata(apb_pwdata),
    .apb_prdata(apb_prdata), .apb_pready(apb_pready), .apb_pslverr(apb_pslverr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  // Expected cycle of the Wishbone termination: SETUP, ACCESS, waits, plus RESP if registered.
  function automatic int exp_latency(input int waits);
    return 2 + waits + RSP;
  endfunction

  // Master presents one request; a slave model inserts 'waits' low-pready ACCESS cycles.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, input int waits, input logic slverr,
                         input logic [31:0] prdata);
    int acc;
    @(posedge clk); #1;
    wbn_cyc = 1'b1; wbn_stb = 1'b1; wbn_we = we; wbn_adr = adr; wbn_sel = sel;
    wbn_dat_w = dat; apb_pslverr = slverr; apb_prdata = prdata; apb_pready = 1'b0;
    acc = 0; obs_cyc = 0; obs_ack = 1'b0; obs_err = 1'b0; obs_dat = '0;
    for (int c = 1; c <= MAXC && obs_cyc == 0; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      apb_pready = apb_penable && (acc >= waits);
      if (apb_penable) acc++;
      #1;
      tr_psel[c] = apb_psel; tr_pen[c] = apb_penable; tr_pwr[c] = apb_pwrite;
      tr_paddr[c] = apb_paddr; tr_pwd[c] = apb_pwdata; tr_pstrb[c] = apb_pstrb;
      if (wbn_ack || wbn_err) begin
        obs_cyc = c; obs_ack = wbn_ack; obs_err = wbn_err; obs_dat = wbn_dat_r;
      end
    end
  endtask

  task automatic wb_idle();
    @(posedge clk); #1;
    wbn_cyc = 1'b0; wbn_stb = 1'b0; apb_pready = 1'b0; apb_pslverr = 1'b0;
  endtask

  task automatic test_reset();
    wbn_cyc = 1'b1; wbn_stb = 1'b1; wbn_we = 1'b1; rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    asserts++; if (apb_psel !== 1'b0) begin fails++; $display("FAIL reset_psel got %b exp 0", apb_psel); end
    asserts++; if (apb_penable !== 1'b0) begin fails++; $display("FAIL reset_penable got %b exp 0", apb_penable); end
    asserts++; if (wbn_ack !== 1'b0 || wbn_err !== 1'b0) begin fails++; $display("FAIL reset_term got ack=%b err=%b exp 0 0", wbn_ack, wbn_err); end
    asserts++; if (wbn_rty !== 1'b0) begin fails++; $display("FAIL reset_rty got %b exp 0", wbn_rty); end
    wbn_cyc = 1'b0; wbn_stb = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    asserts++; if (apb_psel !== 1'b0 || apb_penable !== 1'b0) begin fails++; $display("FAIL idle_after_reset got psel=%b pen=%b exp 0 0", apb_psel, apb_penable); end
  endtask

  task automatic test_write();
    wb_xfer(1'b1, 32'h0000_1004, 4'hF, 32'h0123_4567, 0, 1'b0, 32'hdead_beef);
    asserts++; if (obs_cyc !== exp_latency(0)) begin fails++; $display("FAIL write_latency got %0d exp %0d", obs_cyc, exp_latency(0)); end
    asserts++; if (obs_ack !== 1'b1 || obs_err !== 1'b0) begin fails++; $display("FAIL write_term got ack=%b err=%b exp 1 0", obs_ack, obs_err); end
    asserts++; if (tr_psel[1] !== 1'b1 || tr_pen[1] !== 1'b0) begin fails++; $display("FAIL write_setup got psel=%b pen=%b exp 1 0", tr_psel[1], tr_pen[1]); end
    asserts++; if (tr_psel[2] !== 1'b1 || tr_pen[2] !== 1'b1) begin fails++; $display("FAIL write_access got psel=%b pen=%b exp 1 1", tr_psel[2], tr_pen[2]); end
    asserts++; if (tr_pwr[1] !== 1'b1 || tr_paddr[1] !== 32'h0000_1004) begin fails++; $display("FAIL write_addr got pwrite=%b paddr=%h exp 1 00001004", tr_pwr[1], tr_paddr[1]); end
    asserts++; if (tr_pstrb[1] !== 4'hF || tr_pwd[1] !== 32'h0123_4567) begin fails++; $display("FAIL write_data got pstrb=%h pwdata=%h exp f 01234567", tr_pstrb[1], tr_pwd[1]); end
    if (RSP == 1) begin
      asserts++; if (tr_psel[3] !== 1'b0 || tr_pen[3] !== 1'b0) begin fails++; $display("FAIL resp_phase got psel=%b pen=%b exp 0 0", tr_psel[3], tr_pen[3]); end
    end
    wb_idle();
    #1;
    asserts++; if (wbn_ack !== 1'b0) begin fails++; $display("FAIL write_ack_pulse got %b exp 0", wbn_ack); end
  endtask

  task automatic test_read();
    wb_xfer(1'b0, 32'h0000_1004, 4'hF, 32'h5555_aaaa, 0, 1'b0, 32'h89ab_cdef);
    asserts++; if (tr_pwr[1] !== 1'b0 || tr_pstrb[1] !== 4'h0) begin fails++; $display("FAIL read_ctrl got pwrite=%b pstrb=%h exp 0 0", tr_pwr[1], tr_pstrb[1]); end
    asserts++; if (obs_ack !== 1'b1 || obs_dat !== 32'h89ab_cdef) begin fails++; $display("FAIL read_data got ack=%b dat=%h exp 1 89abcdef", obs_ack, obs_dat); end
    asserts++; if (obs_cyc !== exp_latency(0)) begin fails++; $display("FAIL read_latency got %0d exp %0d", obs_cyc, exp_latency(0)); end
    wb_idle();
  endtask

  task automatic test_wait_states();
    int done_c;
    wb_xfer(1'b0, 32'h0000_2468, 4'h3, 32'h0, 3, 1'b0, 32'h1357_9bdf);
    done_c = exp_latency(3) - RSP;
    asserts++; if (obs_cyc !== exp_latency(3)) begin fails++; $display("FAIL wait_latency got %0d exp %0d", obs_cyc, exp_latency(3)); end
    for (int c = 2; c <= done_c; c++) begin
      asserts++;
      if (tr_psel[c] !== 1'b1 || tr_pen[c] !== 1'b1 || tr_paddr[c] !== 32'h0000_2468) begin
        fails++; $display("FAIL wait_stable c=%0d got psel=%b pen=%b paddr=%h exp 1 1 00002468", c, tr_psel[c], tr_pen[c], tr_paddr[c]);
      end
    end
    wb_idle();
  endtask

  task automatic test_slave_error();
    wb_xfer(1'b1, 32'h0000_3000, 4'h1, 32'hffff_0000, 1, 1'b1, 32'h0);
    asserts++; if (obs_err !== 1'b1 || obs_ack !== 1'b0) begin fails++; $display("FAIL slverr_term got ack=%b err=%b exp 0 1", obs_ack, obs_err); end
    asserts++; if (wbn_rty !== 1'b0) begin fails++; $display("FAIL slverr_rty got %b exp 0", wbn_rty); end
    asserts++; if (obs_cyc !== exp_latency(1)) begin fails++; $display("FAIL slverr_latency got %0d exp %0d", obs_cyc, exp_latency(1)); end
    wb_idle();
  endtask

  task automatic test_back_to_back_reset();
    wb_xfer(1'b1, 32'h0000_1000, 4'hF, 32'haaaa_0001, 0, 1'b0, 32'h0);
    asserts++; if (tr_psel[1] !== 1'b1 || tr_pen[1] !== 1'b0 || tr_paddr[1] !== 32'h0000_1000) begin fails++; $display("FAIL b2b_first_setup got psel=%b pen=%b paddr=%h exp 1 0 00001000", tr_psel[1], tr_pen[1], tr_paddr[1]); end
    asserts++; if (obs_ack !== 1'b1) begin fails++; $display("FAIL b2b_first_ack got %b exp 1", obs_ack); end
    wb_xfer(1'b1, 32'h0000_1004, 4'hF, 32'haaaa_0002, 0, 1'b0, 32'h0);
    asserts++; if (tr_psel[1] !== 1'b1 || tr_pen[1] !== 1'b0 || tr_paddr[1] !== 32'h0000_1004) begin fails++; $display("FAIL b2b_second_setup got psel=%b pen=%b paddr=%h exp 1 0 00001004", tr_psel[1], tr_pen[1], tr_paddr[1]); end
    asserts++; if (obs_cyc !== exp_latency(0) || obs_ack !== 1'b1) begin fails++; $display("FAIL b2b_second_ack got cyc=%0d ack=%b exp %0d 1", obs_cyc, obs_ack, exp_latency(0)); end
    // Third request is aborted by reset while in ACCESS.
    @(posedge clk); #1;
    wbn_adr = 32'h0000_1008; apb_pready = 1'b0;
    @(posedge clk); #1;
    asserts++; if (apb_penable !== 1'b1) begin fails++; $display("FAIL abort_access got pen=%b exp 1", apb_penable); end
    rst = 1'b1; apb_pready = 1'b1;
    #1;
    asserts++; if (apb_psel !== 1'b0 || wbn_ack !== 1'b0 || wbn_err !== 1'b0) begin fails++; $display("FAIL abort_rst got psel=%b ack=%b err=%b exp 0 0 0", apb_psel, wbn_ack, wbn_err); end
    @(posedge clk); #1;
    asserts++; if (apb_penable !== 1'b0 || apb_psel !== 1'b0) begin fails++; $display("FAIL abort_after got psel=%b pen=%b exp 0 0", apb_psel, apb_penable); end
    rst = 1'b0; wbn_cyc = 1'b0; wbn_stb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      asserts++; if (wbn_ack !== 1'b0 || wbn_err !== 1'b0 || apb_psel !== 1'b0) begin fails++; $display("FAIL abort_quiet i=%0d got ack=%b err=%b psel=%b exp 0 0 0", i, wbn_ack, wbn_err, apb_psel); end
    end
    apb_pready = 1'b0;
  endtask

  task automatic test_random();
    logic we, slverr;
    logic [31:0] adr, dat, prd;
    logic [3:0] sel;
    int waits;
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom_range(0, 1)); adr = $urandom; dat = $urandom; prd = $urandom;
      sel = 4'($urandom_range(0, 15)); waits = $urandom_range(0, 3);
      slverr = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) wb_idle();
      wb_xfer(we, adr, sel, dat, waits, slverr, prd);
      asserts++; if (obs_cyc !== exp_latency(waits)) begin fails++; $display("FAIL rnd_latency n=%0d got %0d exp %0d", n, obs_cyc, exp_latency(waits)); end
      asserts++; if (obs_ack !== !slverr || obs_err !== slverr) begin fails++; $display("FAIL rnd_term n=%0d got ack=%b err=%b exp %b %b", n, obs_ack, obs_err, !slverr, slverr); end
      asserts++;
      if (tr_psel[1] !== 1'b1 || tr_pen[1] !== 1'b0 || tr_paddr[1] !== adr || tr_pwr[1] !== we || tr_pwd[1] !== dat) begin
        fails++; $display("FAIL rnd_setup n=%0d got psel=%b pen=%b paddr=%h pwrite=%b pwdata=%h exp 1 0 %h %b %h", n, tr_psel[1], tr_pen[1], tr_paddr[1], tr_pwr[1], tr_pwd[1], adr, we, dat);
      end
      asserts++; if (tr_pstrb[1] !== (we ? sel : 4'h0)) begin fails++; $display("FAIL rnd_pstrb n=%0d got %h exp %h", n, tr_pstrb[1], (we ? sel : 4'h0)); end
      if (!we && !slverr) begin
        asserts++; if (obs_dat !== prd) begin fails++; $display("FAIL rnd_rdata n=%0d got %h exp %h", n, obs_dat, prd); end
      end
    end
    wb_idle();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wait_states();
    test_slave_error();
    test_back_to_back_reset();
    test_random();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
